// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: hold, shift right/left, parallel load, with shift counter
// and word-complete pulse. Define UNIV_SHIFT_REG_ROTATE_EN to add the rot input (rotate modes).
module univ_shift_reg #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       d,
  input  logic                   sin_r,
  input  logic                   sin_l,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  input  logic                   rot,
`endif
  output logic [WIDTH-1:0]       q,
  output logic                   sout_r,
  output logic                   sout_l,
  output logic [$clog2(WIDTH):0] cnt,
  output logic                   word_done
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CntMax = CW'(WIDTH - 1);

  localparam logic [1:0] ModeHold = 2'b00;
  localparam logic [1:0] ModeShr  = 2'b01;
  localparam logic [1:0] ModeShl  = 2'b10;
  localparam logic [1:0] ModeLoad = 2'b11;

  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             fill_r, fill_l;
  logic             shifting;

  // In rotate mode the bit leaving one end re-enters at the other.
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  assign fill_r = rot ? data_q[0]       : sin_r;
  assign fill_l = rot ? data_q[WIDTH-1] : sin_l;
`else
  assign fill_r = sin_r;
  assign fill_l = sin_l;
`endif

  always_comb begin
    data_d   = data_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shifting = 1'b0;
    if (en) begin
      case (mode)
        ModeHold: ;
        ModeShr: begin
          data_d   = {fill_r, data_q[WIDTH-1:1]};
          shifting = 1'b1;
        end
        ModeShl: begin
          data_d   = {data_q[WIDTH-2:0], fill_l};
          shifting = 1'b1;
        end
        ModeLoad: begin
          data_d = d;
          cnt_d  = '0;
        end
        default: ;
      endcase
    end
    // Both directions advance the same word counter.
    if (shifting) begin
      if (cnt_q == CntMax) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      data_q <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q         = data_q;
  assign cnt       = cnt_q;
  assign word_done = done_q;
  assign sout_r    = data_q[0];
  assign sout_l    = data_q[WIDTH-1];

endmodule
